npc_seq: RTL and testbench
==========================

NPC_SEQ -- requirements
Module: npc_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port pc_cur  input  32  current PC register value.
REQ-004 SHALL have port stall  input  1  pipeline stall; blocks sequential and branch advances only.
REQ-005 SHALL have port br_taken  input  1  branch/jump at pc_cur resolved taken.
REQ-006 SHALL have port br_target  input  32  branch/jump target, valid with br_taken.
REQ-007 SHALL have port exc_req  input  1  exception/interrupt request.
REQ-008 SHALL have port eret_req  input  1  ERET at pc_cur.
REQ-009 SHALL have port npc  output  32  next-PC value to the PC register.
REQ-010 SHALL have port pc_en  output  1  normal advance enable.
REQ-011 SHALL have port int_pc_sel  output  1  exception-entry load; overrides stall.
REQ-012 SHALL have port eret_pc_sel  output  1  ERET return load; overrides stall.
REQ-013 SHALL have port epc  output  32  saved exception PC, registered.
REQ-014 SHALL have port exl  output  1  handler-active flag, registered.
REQ-015 SHALL have port bd  output  1  exception taken in delay slot, registered.

Function
REQ-016 SHALL hold a state register with states RUN and DSLOT plus a 32-bit saved-target register.
REQ-017 SHALL compute npc/pc_en/int_pc_sel/eret_pc_sel combinationally from inputs and current state; at most one of the three enables is high per cycle.
REQ-018 SHALL use priority: accepted exception > ERET > branch/DSLOT redirect > sequential.
REQ-019 SHALL accept exc_req only when exl=0; accepted: int_pc_sel=1, npc=32'h0000_4180; next cycle exl=1, state=RUN, saved target discarded.
REQ-020 SHALL capture on accepted exception: epc<=pc_cur, bd<=0 in RUN; epc<=pc_cur-4, bd<=1 in DSLOT.
REQ-021 SHALL ignore exc_req while exl=1 (no latching, no state change).
REQ-022 SHALL on eret_req with exl=1 and no accepted exception: eret_pc_sel=1, npc=epc; next cycle exl=0, state=RUN.
REQ-023 SHALL treat eret_req with exl=0 as a sequential instruction.
REQ-024 SHALL when stall=1 and no exception/ERET: pc_en=0, npc=pc_cur+4, state and saved target unchanged; br_taken ignored (requester holds it).
REQ-025 SHALL in RUN with stall=0: pc_en=1; npc=pc_cur+4 or per REQ-031/REQ-032 on br_taken.
REQ-026 SHALL in DSLOT with stall=0: pc_en=1, npc=saved target, next state RUN; br_taken in DSLOT ignored.
REQ-027 SHALL wrap all PC arithmetic modulo 2^32.
REQ-028 SHALL resolve exc_req and eret_req in the same cycle as the exception only.

Reset
REQ-029 SHALL on reset: state=RUN, saved target=0, epc=0, exl=0, bd=0; reset overrides all same-cycle requests.
REQ-030 SHALL drive during reset cycle pc_en=0, int_pc_sel=0, eret_pc_sel=0, npc=pc_cur+4.

Configuration
REQ-031 SHALL with macro NPC_DELAY_SLOT_EN defined: br_taken in RUN (stall=0) gives npc=pc_cur+4, saves br_target, next state DSLOT.
REQ-032 SHALL without NPC_DELAY_SLOT_EN: br_taken in RUN gives npc=br_target directly; DSLOT unreachable; bd constantly 0; epc always pc_cur.

Verification
REQ-033 SHALL cover: reset then pc_cur=32'h3000, no requests -> npc=32'h3004, pc_en=1; epc=0, exl=0.
REQ-034 SHALL cover (macro on): pc_cur=32'h3010, br_taken, target 32'h3100 -> npc=32'h3014; next cycle pc_cur=32'h3014 -> npc=32'h3100; stall inserted between holds DSLOT.
REQ-035 SHALL cover (macro on): exc_req in DSLOT, pc_cur=32'h3014 -> int_pc_sel=1, npc=32'h4180; then epc=32'h3010, bd=1, exl=1.
REQ-036 SHALL cover: stall=1, exc_req, pc_cur=32'h3020 -> int_pc_sel=1, npc=32'h4180, epc=32'h3020; second exc_req while exl=1 -> ignored.
REQ-037 SHALL cover: exl=1, epc=32'h3020, eret_req -> eret_pc_sel=1, npc=32'h3020; next exl=0; same-cycle exc_req while exl=1 -> ERET still taken.
REQ-038 SHALL cover: reset asserted in DSLOT with exl=1 -> next cycle RUN, exl=0, epc=0.

Source files
------------

// File: rtl/npc_seq.sv
// rtl/npc_seq.sv - next-PC sequencer with exception entry, ERET return and branch redirect
// Optional delayed-branch support is enabled by defining NPC_DELAY_SLOT_EN.
module npc_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  output logic [31:0] npc,
  output logic        pc_en,
  output logic        int_pc_sel,
  output logic        eret_pc_sel,
  output logic [31:0] epc,
  output logic        exl,
  output logic        bd
);

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic {RUN, DSLOT} state_t;

  state_t      state, next_state;
  logic [31:0] saved_target, next_target;
  logic [31:0] pc_plus4;
  logic        exc_accept;
  logic        eret_accept;

  assign pc_plus4    = pc_cur + 32'd4;
  assign exc_accept  = !reset && exc_req && !exl;
  assign eret_accept = !reset && !exc_accept && eret_req && exl;

  always_comb begin
    npc         = pc_plus4;
    pc_en       = 1'b0;
    int_pc_sel  = 1'b0;
    eret_pc_sel = 1'b0;
    next_state  = state;
    next_target = saved_target;
    if (reset) begin
      next_state = RUN;
    end else if (exc_accept) begin
      int_pc_sel = 1'b1;
      npc        = EXC_VECTOR;
    end else if (eret_accept) begin
      eret_pc_sel = 1'b1;
      npc         = epc;
    end else if (!stall) begin
      pc_en = 1'b1;
      if (state == DSLOT) begin
        // Delay-slot instruction retires; the held branch target is applied now.
        npc        = saved_target;
        next_state = RUN;
      end else if (br_taken) begin
`ifdef NPC_DELAY_SLOT_EN
        npc         = pc_plus4;
        next_target = br_target;
        next_state  = DSLOT;
`else
        npc = br_target;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      saved_target <= 32'd0;
      epc          <= 32'd0;
      exl          <= 1'b0;
      bd           <= 1'b0;
    end else if (exc_accept) begin
      state        <= RUN;
      saved_target <= 32'd0;
      exl          <= 1'b1;
`ifdef NPC_DELAY_SLOT_EN
      // Faulting in a delay slot restarts at the branch so the branch re-executes.
      epc <= (state == DSLOT) ? pc_cur - 32'd4 : pc_cur;
      bd  <= (state == DSLOT);
`else
      epc <= pc_cur;
      bd  <= 1'b0;
`endif
    end else if (eret_accept) begin
      state <= RUN;
      exl   <= 1'b0;
    end else begin
      state        <= next_state;
      saved_target <= next_target;
    end
  end

endmodule

// File: tb/tb_npc_seq.sv
// tb/tb_npc_seq.sv - directed self-checking bench for npc_seq
module tb_npc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] npc;
  logic        pc_en;
  logic        int_pc_sel;
  logic        eret_pc_sel;
  logic [31:0] epc;
  logic        exl;
  logic        bd;

  int checks = 0;
  int errors = 0;

  npc_seq dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .exc_req(exc_req),
    .eret_req(eret_req), .npc(npc), .pc_en(pc_en), .int_pc_sel(int_pc_sel),
    .eret_pc_sel(eret_pc_sel), .epc(epc), .exl(exl), .bd(bd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle, then let combinational outputs settle.
  task automatic drive(input logic rst, input logic [31:0] pc, input logic stl,
                       input logic br, input logic [31:0] tgt,
                       input logic exc, input logic eret);
    reset = rst; pc_cur = pc; stall = stl; br_taken = br;
    br_target = tgt; exc_req = exc; eret_req = eret;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_en(input string tag, input logic [31:0] exp_npc,
                          input logic exp_pc_en, input logic exp_int, input logic exp_eret);
    check({tag, ".npc"}, npc, exp_npc);
    check({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, exp_pc_en});
    check({tag, ".int"}, {31'd0, int_pc_sel}, {31'd0, exp_int});
    check({tag, ".eret"}, {31'd0, eret_pc_sel}, {31'd0, exp_eret});
  endtask

  task automatic check_regs(input string tag, input logic [31:0] exp_epc,
                            input logic exp_exl, input logic exp_bd);
    check({tag, ".epc"}, epc, exp_epc);
    check({tag, ".exl"}, {31'd0, exl}, {31'd0, exp_exl});
    check({tag, ".bd"}, {31'd0, bd}, {31'd0, exp_bd});
  endtask

  initial begin
    @(negedge clk);
    // Reset overrides a same-cycle exception request.
    drive(1, 32'h3000, 0, 0, 32'h0, 1, 0);
    check_en("rst_cycle", 32'h3004, 0, 0, 0);
    step();
    check_regs("after_rst", 32'h0, 0, 0);

    drive(0, 32'h3000, 0, 0, 32'h0, 0, 0);
    check_en("seq", 32'h3004, 1, 0, 0);
    step();

`ifdef NPC_DELAY_SLOT_EN
    drive(0, 32'h3010, 0, 1, 32'h3100, 0, 0);
    check_en("br_ds", 32'h3014, 1, 0, 0);
    step();
    drive(0, 32'h3014, 1, 1, 32'h3200, 0, 0);
    check_en("ds_stall", 32'h3018, 0, 0, 0);
    step();
    drive(0, 32'h3014, 0, 1, 32'h3200, 0, 0);
    check_en("ds_redirect", 32'h3100, 1, 0, 0);
    step();
    drive(0, 32'h3010, 0, 1, 32'h3100, 0, 0);
    step();
    drive(0, 32'h3014, 0, 0, 32'h0, 1, 0);
    check_en("exc_ds", 32'h4180, 0, 1, 0);
    step();
    check_regs("exc_ds_regs", 32'h3010, 1, 1);
    // Saved target was discarded: sequential flow after the handler entry.
    drive(0, 32'h4180, 0, 0, 32'h0, 0, 0);
    check_en("post_exc_seq", 32'h4184, 1, 0, 0);
    step();
    drive(0, 32'h4184, 0, 0, 32'h0, 0, 1);
    check_en("eret_ds", 32'h3010, 0, 0, 1);
    step();
    check_regs("eret_ds_regs", 32'h3010, 0, 1);
`else
    drive(0, 32'h3010, 0, 1, 32'h3100, 0, 0);
    check_en("br_direct", 32'h3100, 1, 0, 0);
    step();
`endif

    drive(0, 32'h3040, 1, 1, 32'h5000, 0, 0);
    check_en("stall_br", 32'h3044, 0, 0, 0);
    step();

    drive(0, 32'h3020, 1, 0, 32'h0, 1, 0);
    check_en("exc_stall", 32'h4180, 0, 1, 0);
    step();
    check_regs("exc_regs", 32'h3020, 1, 0);

    drive(0, 32'h3024, 0, 0, 32'h0, 1, 0);
    check_en("exc_ignored", 32'h3028, 1, 0, 0);
    step();
    check_regs("exc_ignored_regs", 32'h3020, 1, 0);

    drive(0, 32'h3028, 0, 0, 32'h0, 1, 1);
    check_en("eret_w_exc", 32'h3020, 0, 0, 1);
    step();
    check_regs("eret_regs", 32'h3020, 0, 0);

    drive(0, 32'h3030, 0, 0, 32'h0, 0, 1);
    check_en("eret_exl0", 32'h3034, 1, 0, 0);
    step();

    drive(0, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 0);
    check_en("wrap", 32'h0, 1, 0, 0);
    step();

    // Enter the handler, then reset (in a delay slot when that feature exists).
    drive(0, 32'h3050, 0, 0, 32'h0, 1, 0);
    step();
`ifdef NPC_DELAY_SLOT_EN
    drive(0, 32'h3010, 0, 1, 32'h3100, 0, 0);
    check_en("br_in_handler", 32'h3014, 1, 0, 0);
    step();
`endif
    check_regs("pre_rst", 32'h3050, 1, 0);
    drive(1, 32'h3014, 0, 0, 32'h0, 0, 0);
    check_en("rst_in_ds", 32'h3018, 0, 0, 0);
    step();
    check_regs("post_rst", 32'h0, 0, 0);
    drive(0, 32'h3014, 0, 0, 32'h0, 0, 0);
    check_en("post_rst_run", 32'h3018, 1, 0, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
